// File: rtl/picture_fetch_ctrl.sv
// picture_fetch_ctrl: walks the picture ROM once per frame, absorbs the ROM
// read latency in a small skid buffer and pushes pixels into the write-side
// pixel FIFO under fifo_full backpressure. Reports frame completion and a
// sticky overrun when a frame is restarted before it was fully delivered.
module picture_fetch_ctrl #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 24,
  parameter int NUM_PIXELS = 4800,
  parameter int ROM_LAT    = 2,
  parameter int SKID_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              frame_start,
  output logic              rom_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_din,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  localparam int CNT_W  = $clog2(NUM_PIXELS + 1);
  localparam int PTR_W  = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int SCNT_W = $clog2(SKID_DEPTH + 1);
  localparam int INF_W  = $clog2(ROM_LAT + 1);
  localparam int OCC_W  = $clog2(ROM_LAT + SKID_DEPTH + 1);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PIXELS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_PIXELS);
  localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(SKID_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(SKID_DEPTH - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Frame progress counters: addresses issued and pixels written
  logic [CNT_W-1:0]  r_issue_cnt;
  logic [CNT_W-1:0]  r_wr_cnt;

  // One bit per outstanding ROM read; the top bit marks rom_data valid now
  logic [ROM_LAT-1:0] r_rom_vld;

  // Skid buffer storage and bookkeeping
  logic [DATA_W-1:0] r_skid_mem [SKID_DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [SCNT_W-1:0] r_skid_cnt;

  logic              r_done;
  logic              r_overrun;

  logic              w_fetch;
  logic [INF_W-1:0]  w_inflight;
  logic [OCC_W-1:0]  w_occ;
  logic              w_can_wr;
  logic              w_last_wr;
  logic              w_delivered;
  logic              w_restart;
  logic              w_abort;
  logic              w_start;
  logic              w_clear;
  logic              w_issue;
  logic              w_wr;
  logic              w_push;
  logic [ADDR_W-1:0] w_addr;

  // Circular pointer advance over a possibly non-power-of-two depth
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // ROM address is the issue counter, zero-extended or truncated to ADDR_W
  if (CNT_W >= ADDR_W) begin : g_addr_trunc
    assign w_addr = r_issue_cnt[ADDR_W-1:0];
  end else begin : g_addr_ext
    assign w_addr = {{(ADDR_W - CNT_W){1'b0}}, r_issue_cnt};
  end

  // Count reads still travelling through the ROM pipeline
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < ROM_LAT; i++) begin
      w_inflight = w_inflight + INF_W'(r_rom_vld[i]);
    end
  end

  // Issue / write / restart decisions, all from registered state and inputs
  always_comb begin
    w_fetch     = (r_state == S_FETCH);
    w_occ       = OCC_W'(w_inflight) + OCC_W'(r_skid_cnt);
    w_can_wr    = w_fetch && (r_skid_cnt != '0) && !fifo_full;
    w_last_wr   = w_can_wr && (r_wr_cnt == LAST_CNT);
    w_delivered = (r_wr_cnt == FULL_CNT);
    // Any frame_start in FETCH restarts the frame; it only counts as an
    // overrun when the current frame has not been completely written.
    w_restart   = w_fetch && frame_start;
    w_abort     = w_restart && !w_last_wr && !w_delivered;
    w_start     = !w_fetch && frame_start;
    w_clear     = w_start || w_restart;
    w_wr        = w_can_wr && !w_abort;
    // Credit is taken from registered counts only; a pop this cycle does
    // not free a slot until next cycle, which bounds skid occupancy.
    w_issue     = w_fetch && enable && (r_issue_cnt < FULL_CNT) &&
                  (w_occ < OCC_MAX) && !w_restart;
    w_push      = r_rom_vld[ROM_LAT-1] && !w_clear;
  end

  // Next-state logic for IDLE/FETCH
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (frame_start) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        // Stay in FETCH through the frame_done cycle, then drop to IDLE
        if (!frame_start && w_delivered) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Issue and write counters, zeroed on every frame (re)start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue_cnt <= '0;
      r_wr_cnt    <= '0;
    end else if (w_clear) begin
      r_issue_cnt <= '0;
      r_wr_cnt    <= '0;
    end else begin
      if (w_issue) r_issue_cnt <= r_issue_cnt + CNT_W'(1);
      if (w_wr)    r_wr_cnt    <= r_wr_cnt + CNT_W'(1);
    end
  end

  // ROM valid shift register; clearing it discards data of an aborted frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_vld <= '0;
    end else if (w_clear) begin
      r_rom_vld <= '0;
    end else begin
      r_rom_vld[0] <= w_issue;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_rom_vld[i] <= r_rom_vld[i-1];
      end
    end
  end

  // Skid buffer pointers and occupancy; simultaneous push and pop keep count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_skid_cnt <= '0;
    end else if (w_clear) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_skid_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_wr)   r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_wr})
        2'b10:   r_skid_cnt <= r_skid_cnt + SCNT_W'(1);
        2'b01:   r_skid_cnt <= r_skid_cnt - SCNT_W'(1);
        default: r_skid_cnt <= r_skid_cnt;
      endcase
    end
  end

  // Skid buffer storage; cleared on reset so fifo_din reads 0 out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        r_skid_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_skid_mem[r_wr_ptr] <= rom_data;
    end
  end

  // Frame-done pulse and sticky overrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_done <= w_last_wr;
      if (w_abort) r_overrun <= 1'b1;
    end
  end

  assign rom_en     = w_issue;
  assign mem_addr   = w_issue ? w_addr : '0;
  assign fifo_wr_en = w_wr;
  assign fifo_din   = r_skid_mem[r_rd_ptr];
  assign busy       = w_fetch;
  assign frame_done = r_done;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_picture_fetch_ctrl.sv
// Testbench for picture_fetch_ctrl with an 8-pixel frame and a ROM that
// returns its own address after ROM_LAT cycles.
module tb_picture_fetch_ctrl;

  localparam int ADDR_W     = 13;
  localparam int DATA_W     = 24;
  localparam int NUM_PIXELS = 8;
  localparam int ROM_LAT    = 2;
  localparam int SKID_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic              frame_start = 1'b0;
  logic              fifo_full = 1'b0;
  logic              rom_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] rom_data;
  logic              fifo_wr_en;
  logic [DATA_W-1:0] fifo_din;
  logic              busy;
  logic              frame_done;
  logic              overrun;

  int errors = 0;
  int checks = 0;

  picture_fetch_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_PIXELS(NUM_PIXELS),
    .ROM_LAT(ROM_LAT), .SKID_DEPTH(SKID_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_start(frame_start),
    .rom_en(rom_en), .mem_addr(mem_addr), .rom_data(rom_data),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // ROM model: data = address, two-cycle latency
  logic [ADDR_W-1:0] rom_q0, rom_q1;
  always @(posedge clk) begin
    rom_q0 <= mem_addr;
    rom_q1 <= rom_q0;
  end
  assign rom_data = {{(DATA_W - ADDR_W){1'b0}}, rom_q1};

  // FIFO-side monitor, sampled on the falling edge
  logic [DATA_W-1:0] wr_log [$];
  int wr_n = 0, rom_n = 0, done_n = 0, full_wr_n = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_wr_en) begin
        wr_log.push_back(fifo_din);
        wr_n++;
        if (fifo_full) full_wr_n++;
      end
      if (rom_en) rom_n++;
      if (frame_done) done_n++;
    end
  end

  typedef struct {
    logic fs;
    logic full;
    logic rom;
    int   addr;
    logic wr;
    int   din;
    logic bsy;
    logic dn;
    logic ovr;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    wr_log.delete();
    wr_n = 0; rom_n = 0; done_n = 0; full_wr_n = 0;
  endtask

  // Expect exactly pixels 0..NUM_PIXELS-1 in order
  task automatic chk_frame(input string name);
    chk({name, "_count"}, 32'(wr_log.size()), 32'(NUM_PIXELS));
    for (int i = 0; i < NUM_PIXELS; i++) begin
      if (i < wr_log.size()) chk({name, "_pix"}, 32'(wr_log[i]), 32'(i));
    end
  endtask

  task automatic wait_done(input int target, input string name);
    for (int c = 0; c < 300 && done_n < target; c++) tick();
    chk({name, "_done_seen"}, 32'(done_n), 32'(target));
  endtask

  initial begin
    vt[0]  = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 1'b1, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 1'b1, 1, 1'b0, 0, 1'b1, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 1'b1, 2, 1'b0, 0, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 1'b1, 3, 1'b1, 0, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 1'b1, 4, 1'b1, 1, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 1'b1, 5, 1'b1, 2, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 1'b1, 6, 1'b1, 3, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 1'b1, 7, 1'b1, 4, 1'b1, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 0, 1'b1, 5, 1'b1, 1'b0, 1'b0};
    vt[10] = '{1'b0, 1'b0, 1'b0, 0, 1'b1, 6, 1'b1, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b0, 1'b0, 0, 1'b1, 7, 1'b1, 1'b0, 1'b0};
    vt[12] = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b1, 1'b0};
    vt[13] = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0};

    // Reset state
    rst_n = 1'b0;
    tick(); tick();
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rom_en", 32'(rom_en), 32'd0);
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_din", 32'(fifo_din), 32'd0);
    tick();
    rst_n = 1'b1;
    enable = 1'b1;
    tick();

    // Basic frame, cycle-exact against the table
    clr_mon();
    for (int k = 0; k < 14; k++) begin
      frame_start = vt[k].fs;
      fifo_full   = vt[k].full;
      #2;
      chk($sformatf("t1_c%0d_rom_en", k), 32'(rom_en), 32'(vt[k].rom));
      if (vt[k].rom) chk($sformatf("t1_c%0d_addr", k), 32'(mem_addr), 32'(vt[k].addr));
      chk($sformatf("t1_c%0d_wr_en", k), 32'(fifo_wr_en), 32'(vt[k].wr));
      if (vt[k].wr) chk($sformatf("t1_c%0d_din", k), 32'(fifo_din), 32'(vt[k].din));
      chk($sformatf("t1_c%0d_busy", k), 32'(busy), 32'(vt[k].bsy));
      chk($sformatf("t1_c%0d_done", k), 32'(frame_done), 32'(vt[k].dn));
      chk($sformatf("t1_c%0d_ovr", k), 32'(overrun), 32'(vt[k].ovr));
      tick();
    end
    chk("t1_done_count", 32'(done_n), 32'd1);

    // Backpressure: fifo_full held over cycles 4..20
    clr_mon();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      fifo_full = (c >= 4);
      tick();
    end
    chk("t2_no_wr_while_full", 32'(wr_n), 32'd0);
    chk("t2_rom_en_bounded", 32'(rom_n), 32'd4);
    fifo_full = 1'b0;
    wait_done(1, "t2");
    chk_frame("t2");
    #1;
    chk("t2_idle_after", 32'(busy), 32'd0);

    // enable gap plus random backpressure
    clr_mon();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int c = 1; c < 400 && done_n == 0; c++) begin
      enable    = !(c >= 5 && c < 10);
      fifo_full = 1'($urandom_range(0, 1));
      tick();
    end
    enable = 1'b1;
    fifo_full = 1'b0;
    chk("t3_done_seen", 32'(done_n), 32'd1);
    chk_frame("t3");
    chk("t3_no_wr_when_full", 32'(full_wr_n), 32'd0);
    tick(); tick(); tick();
    chk("t3_single_done", 32'(done_n), 32'd1);

    // Restart mid-frame at cycle 6
    clr_mon();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int c = 1; c < 6; c++) tick();
    chk("t4_pre_abort_writes", 32'(wr_n), 32'd2);
    frame_start = 1'b1;
    #2;
    chk("t4_abort_no_wr", 32'(fifo_wr_en), 32'd0);
    tick();
    frame_start = 1'b0;
    #1;
    chk("t4_overrun", 32'(overrun), 32'd1);
    chk("t4_busy", 32'(busy), 32'd1);
    clr_mon();
    wait_done(1, "t4");
    chk_frame("t4");
    chk("t4_overrun_sticky", 32'(overrun), 32'd1);

    // Asynchronous reset mid-frame
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int c = 1; c < 6; c++) tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_rom_en", 32'(rom_en), 32'd0);
    chk("t6_rst_addr", 32'(mem_addr), 32'd0);
    chk("t6_rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("t6_rst_din", 32'(fifo_din), 32'd0);
    chk("t6_rst_done", 32'(frame_done), 32'd0);
    chk("t6_rst_overrun", 32'(overrun), 32'd0);
    tick(); tick();
    chk("t6_rst_hold_wr_en", 32'(fifo_wr_en), 32'd0);
    rst_n = 1'b1;
    tick();

    // Clean frame, then frame_start on the final write
    clr_mon();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int c = 1; c < 11; c++) tick();
    frame_start = 1'b1;
    #2;
    chk("t5_final_wr", 32'(fifo_wr_en), 32'd1);
    chk("t5_final_din", 32'(fifo_din), 32'd7);
    tick();
    frame_start = 1'b0;
    #2;
    chk("t5_done_pulse", 32'(frame_done), 32'd1);
    chk("t5_busy_held", 32'(busy), 32'd1);
    chk("t5_restart_rom_en", 32'(rom_en), 32'd1);
    chk("t5_restart_addr", 32'(mem_addr), 32'd0);
    chk("t5_no_overrun", 32'(overrun), 32'd0);
    chk_frame("t5_first");
    wr_log.delete();
    wait_done(2, "t5");
    chk_frame("t5_second");
    chk("t5_overrun_clear", 32'(overrun), 32'd0);
    #1;
    chk("t5_idle_after", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
